// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency 64-bit single-port memory between fetch and MEM.
// Data has fixed priority; per-port stalls and saturating wait counters.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [63:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_ready,
  output logic             if_stall,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [63:0]      d_addr,
  input  logic [63:0]      d_wdata,
  output logic [63:0]      d_rdata,
  output logic             d_ready,
  output logic             d_stall,
  output logic             m_en,
  output logic             m_we,
  output logic [63:0]      m_addr,
  output logic [63:0]      m_wdata,
  input  logic [63:0]      m_rdata,
  output logic [CNT_W-1:0] if_wait_cnt,
  output logic [CNT_W-1:0] d_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              m_en_q;
  logic              m_we_q;
  logic [63:0]       m_addr_q;
  logic [63:0]       m_wdata_q;
  logic              sel_q;
  logic [CNT_W-1:0]  if_wait_q, if_wait_d;
  logic [CNT_W-1:0]  d_wait_q, d_wait_d;
  logic              d_req;
  logic              last;

  assign d_req = d_read | d_write;
  assign last  = (cnt_q == 4'd0);

  assign if_ready = (state_q == BUSY_I) && last;
  assign d_ready  = (state_q == BUSY_D) && last;
  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

  assign d_rdata  = m_rdata;
  assign if_rdata = sel_q ? m_rdata[63:32] : m_rdata[31:0];

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign if_wait_cnt = if_wait_q;
  assign d_wait_cnt  = d_wait_q;

  always_comb begin
    if_wait_d = if_wait_q;
    d_wait_d  = d_wait_q;
    if (if_stall && (if_wait_q != '1))
      if_wait_d = if_wait_q + CNT_W'(1);
    if (d_stall && (d_wait_q != '1))
      d_wait_d = d_wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_wait_q <= '0;
      d_wait_q  <= '0;
    end else begin
      if_wait_q <= if_wait_d;
      d_wait_q  <= d_wait_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 64'd0;
      m_wdata_q <= 64'd0;
      sel_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_req) begin
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_we_q    <= d_write;
            m_en_q    <= 1'b1;
            cnt_q     <= LAT_M1;
            state_q   <= BUSY_D;
          end else if (if_req) begin
            m_addr_q <= if_addr;
            m_we_q   <= 1'b0;
            sel_q    <= if_addr[2];
            m_en_q   <= 1'b1;
            cnt_q    <= LAT_M1;
            state_q  <= BUSY_I;
          end else begin
            m_en_q <= 1'b0;
            m_we_q <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (!last) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            m_en_q  <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
